// File: rtl/xcvr_reset_pkg.sv
// Shared types, default timing and counter sizing helpers for the TX reset sequencer.
package xcvr_reset_pkg;

  typedef enum logic [1:0] {
    ANALOG,
    LOCK_WAIT,
    DIGITAL,
    READY
  } lane_state_e;

  localparam int unsigned DEF_T_PLL_PD      = 1000;
  localparam int unsigned DEF_T_ANALOG      = 70;
  localparam int unsigned DEF_T_LOCK_STABLE = 16;
  localparam int unsigned DEF_T_DIGITAL     = 20;

  function automatic int unsigned cnt_w(input int unsigned t);
    return $clog2(t) + 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/xcvr_tx_reset_lane.sv
// One TX lane reset FSM: analog reset, lock debounce, digital reset, ready.
module xcvr_tx_reset_lane
  import xcvr_reset_pkg::*;
#(
  parameter int unsigned T_ANALOG      = DEF_T_ANALOG,
  parameter int unsigned T_LOCK_STABLE = DEF_T_LOCK_STABLE,
  parameter int unsigned T_DIGITAL     = DEF_T_DIGITAL
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pd_done,
  input  logic cal_busy,
  input  logic locked,
  input  logic reset_req,
  output logic analogreset,
  output logic digitalreset,
  output logic ready
);

  localparam int unsigned CntW = cnt_w(max3(T_ANALOG, T_LOCK_STABLE, T_DIGITAL));

  lane_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            busy_q;
  logic            busy_rise;

  assign busy_rise = cal_busy & ~busy_q;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (reset_req || busy_rise) begin
      state_d = ANALOG;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ANALOG: begin
          if (cal_busy) begin
            cnt_d = '0;
          end else if (pd_done) begin
            if (cnt_q == CntW'(T_ANALOG - 1)) begin
              state_d = LOCK_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        LOCK_WAIT: begin
          if (!locked) begin
            cnt_d = '0;
          end else if (cnt_q == CntW'(T_LOCK_STABLE - 1)) begin
            state_d = DIGITAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DIGITAL: begin
          if (!locked) begin
            state_d = LOCK_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(T_DIGITAL - 1)) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        READY: begin
          if (!locked) begin
            state_d = LOCK_WAIT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ANALOG;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the registered state, so they trail a transition by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ANALOG;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      analogreset  <= 1'b1;
      digitalreset <= 1'b1;
      ready        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= cal_busy;
      analogreset  <= (state_q == ANALOG);
      digitalreset <= (state_q != READY);
      ready        <= (state_q == READY);
    end
  end

endmodule

// File: rtl/xcvr_tx_reset_seq.sv
// Parametrised TX reset sequencer: input synchronisers, shared PLL powerdown timer and per-lane FSMs.
module xcvr_tx_reset_seq
  import xcvr_reset_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned NUM_PLLS      = 1,
  parameter int unsigned T_PLL_PD      = DEF_T_PLL_PD,
  parameter int unsigned T_ANALOG      = DEF_T_ANALOG,
  parameter int unsigned T_LOCK_STABLE = DEF_T_LOCK_STABLE,
  parameter int unsigned T_DIGITAL     = DEF_T_DIGITAL,
  localparam int unsigned SEL_W        = (NUM_PLLS > 1) ? $clog2(NUM_PLLS) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  output logic [NUM_PLLS-1:0]           pll_powerdown,
  output logic [NUM_CHANNELS-1:0]       tx_analogreset,
  output logic [NUM_CHANNELS-1:0]       tx_digitalreset,
  output logic [NUM_CHANNELS-1:0]       tx_ready,
  input  logic [NUM_PLLS-1:0]           pll_locked,
  input  logic [NUM_CHANNELS*SEL_W-1:0] pll_select,
  input  logic [NUM_CHANNELS-1:0]       tx_cal_busy,
  input  logic [NUM_CHANNELS-1:0]       chan_reset_req
);

  localparam int unsigned PdW = cnt_w(T_PLL_PD);

  logic [NUM_PLLS-1:0]     locked_s1, locked_s2;
  logic [NUM_CHANNELS-1:0] busy_s1, busy_s2;
  logic [NUM_CHANNELS-1:0] lane_locked;
  logic [PdW-1:0]          pd_cnt_q;
  logic                    pd_done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      locked_s1 <= '0;
      locked_s2 <= '0;
      busy_s1   <= '0;
      busy_s2   <= '0;
    end else begin
      locked_s1 <= pll_locked;
      locked_s2 <= locked_s1;
      busy_s1   <= tx_cal_busy;
      busy_s2   <= busy_s1;
    end
  end

  // Counter parks at T_PLL_PD-1 once done, so it never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pd_cnt_q  <= '0;
      pd_done_q <= 1'b0;
    end else if (!pd_done_q) begin
      if (pd_cnt_q == PdW'(T_PLL_PD - 1)) begin
        pd_done_q <= 1'b1;
      end else begin
        pd_cnt_q <= pd_cnt_q + 1'b1;
      end
    end
  end

  assign pll_powerdown = {NUM_PLLS{~pd_done_q}};

  // An out-of-range selection matches no PLL and reads as unlocked.
  always_comb begin
    lane_locked = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      for (int unsigned p = 0; p < NUM_PLLS; p++) begin
        if (pll_select[c*SEL_W +: SEL_W] == SEL_W'(p)) begin
          lane_locked[c] = locked_s2[p];
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    xcvr_tx_reset_lane #(
      .T_ANALOG      (T_ANALOG),
      .T_LOCK_STABLE (T_LOCK_STABLE),
      .T_DIGITAL     (T_DIGITAL)
    ) u_lane (
      .clock        (clock),
      .reset_n      (reset_n),
      .pd_done      (pd_done_q),
      .cal_busy     (busy_s2[c]),
      .locked       (lane_locked[c]),
      .reset_req    (chan_reset_req[c]),
      .analogreset  (tx_analogreset[c]),
      .digitalreset (tx_digitalreset[c]),
      .ready        (tx_ready[c])
    );
  end

endmodule
